// File: rtl/sgd_pkg.sv
// sgd_pkg -- shared definitions for the SGD DSP blocks.
//   DATA_WIDTH   : datapath width of every operand, partial sum and result.
//   data_t       : signed datapath word.
//   lane_offset  : start lane of adder-tree level l inside a flat node vector
//                  holding the masked inputs followed by every level's outputs.
package sgd_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  // Level l consumes n_lanes >> l values. Levels are stored back to back, so
  // the start of level l is n + n/2 + ... (l terms) = 2n - (2n >> l).
  function automatic int lane_offset(input int n_lanes, input int level);
    return (2 * n_lanes) - ((2 * n_lanes) >> level);
  endfunction

endpackage

// File: rtl/sgd_add_tree_level.sv
// sgd_add_tree_level -- one level of the binary adder tree.
//   Adds adjacent lane pairs (2k, 2k+1) with 32-bit wrap-around arithmetic.
//   REGISTERED=1 : results are captured every clock; async active-low clear.
//   REGISTERED=0 : results are purely combinational; clk/rst_n are ignored.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   in_data    : IN_LANES packed words, lane i at bits [i*W +: W]
//   out_data   : IN_LANES/2 packed words, same lane packing
module sgd_add_tree_level
  import sgd_pkg::*;
#(
  parameter int IN_LANES   = 2,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [IN_LANES*DATA_WIDTH-1:0]       in_data,
  output logic [(IN_LANES/2)*DATA_WIDTH-1:0]   out_data
);

  localparam int OUT_LANES = IN_LANES / 2;

  logic [OUT_LANES*DATA_WIDTH-1:0] sum;

  // Plain "+" on flat operands keeps each adder DSP-inferable. The result is
  // kept at DATA_WIDTH, so overflow wraps modulo 2**32.
  always_comb begin
    sum = '0;
    for (int k = 0; k < OUT_LANES; k++) begin
      sum[k*DATA_WIDTH +: DATA_WIDTH] = in_data[(2*k)*DATA_WIDTH +: DATA_WIDTH]
                                      + in_data[(2*k+1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  if (REGISTERED) begin : g_reg
    // Free-running: loads every cycle, independent of any valid qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data <= '0;
      end else begin
        out_data <= sum;
      end
    end
  end else begin : g_comb
    assign out_data = sum;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

endmodule

// File: rtl/sgd_dsp_add_tree.sv
// sgd_dsp_add_tree -- pipelined masked sum of 2**TREE_DEPTH signed lanes.
//   Level 0 masks each lane by its enable, then TREE_DEPTH binary adder levels
//   reduce to one 32-bit wrapped sum. The first TREE_TRI_DEPTH levels are
//   combinational, the rest registered, giving latency
//   L = TREE_DEPTH - TREE_TRI_DEPTH cycles.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   v_input         : N signed operand lanes
//   v_input_valid   : qualifies v_input / v_input_enable for one cycle
//   v_input_enable  : per-lane include mask (0 = lane contributes zero)
//   v_output        : masked sum
//   v_output_valid  : qualifies v_output for one cycle
//
// Handshake: valid-only, no ready. Every cycle with v_input_valid=1 is accepted
// unconditionally; exactly L cycles later v_output_valid=1 for one cycle with
// that beat's sum on v_output. Back-to-back beats stream at one per cycle.
// When v_output_valid=0, v_output carries don't-care (deterministic) data.
module sgd_dsp_add_tree
  import sgd_pkg::*;
#(
  parameter int TREE_DEPTH     = 3,
  parameter int TREE_TRI_DEPTH = 0,
  localparam int N             = 1 << TREE_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic signed [DATA_WIDTH-1:0] v_input [N-1:0],
  input  logic         v_input_valid,
  input  logic         v_input_enable [N-1:0],
  output logic signed [DATA_WIDTH-1:0] v_output,
  output logic         v_output_valid
);

  localparam int LATENCY     = TREE_DEPTH - TREE_TRI_DEPTH;
  localparam int TOTAL_NODES = 2 * N - 1;

  // Masked inputs at lanes [0, N), then each level's results appended.
  logic [TOTAL_NODES*DATA_WIDTH-1:0] nodes;

  for (genvar i = 0; i < N; i++) begin : g_mask
    assign nodes[i*DATA_WIDTH +: DATA_WIDTH] = v_input_enable[i] ? v_input[i] : '0;
  end

  for (genvar l = 0; l < TREE_DEPTH; l++) begin : g_lvl
    localparam int IN_LANES = N >> l;
    localparam int IN_OFF   = lane_offset(N, l);
    localparam int OUT_OFF  = lane_offset(N, l + 1);

    sgd_add_tree_level #(
      .IN_LANES   (IN_LANES),
      .REGISTERED (l >= TREE_TRI_DEPTH)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (nodes[IN_OFF*DATA_WIDTH +: IN_LANES*DATA_WIDTH]),
      .out_data (nodes[OUT_OFF*DATA_WIDTH +: (IN_LANES/2)*DATA_WIDTH])
    );
  end

  assign v_output = nodes[(TOTAL_NODES-1)*DATA_WIDTH +: DATA_WIDTH];

  // Valid delay line: one stage per registered level, so it tracks the data
  // and is cleared with it on reset (in-flight sums are never flagged).
  logic [LATENCY-1:0] valid_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= v_input_valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
      end
    end
  end

  assign v_output_valid = valid_sr[LATENCY-1];

endmodule

// File: tb/tb_sgd_dsp_add_tree.sv
// tb_sgd_dsp_add_tree -- directed scoreboard bench for sgd_dsp_add_tree.
// Two instances share one stimulus stream: dut0 with defaults (latency 3) and
// dut1 with TREE_TRI_DEPTH=1 (latency 2). Each beat pushes the hand-computed
// sum and its due cycle into per-instance queues; a negedge monitor pops and
// checks value and arrival cycle whenever an instance raises v_output_valid.
module tb_sgd_dsp_add_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [31:0] v_input [7:0];
  logic               v_input_valid;
  logic               v_input_enable [7:0];
  logic signed [31:0] out0, out1;
  logic               vld0, vld1;

  sgd_dsp_add_tree #(.TREE_DEPTH(3), .TREE_TRI_DEPTH(0)) dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .v_input        (v_input),
    .v_input_valid  (v_input_valid),
    .v_input_enable (v_input_enable),
    .v_output       (out0),
    .v_output_valid (vld0)
  );

  sgd_dsp_add_tree #(.TREE_DEPTH(3), .TREE_TRI_DEPTH(1)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .v_input        (v_input),
    .v_input_valid  (v_input_valid),
    .v_input_enable (v_input_enable),
    .v_output       (out1),
    .v_output_valid (vld1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          exp_t0[$];
  int          exp_t1[$];

  logic signed [31:0] din [8];
  logic               den [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one valid beat from din/den. keep=0 issues a beat that reset will
  // discard; rel=1 releases reset in the same half-cycle.
  task automatic send(input logic [31:0] exp, input bit keep, input bit rel);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_input[i]        = din[i];
      v_input_enable[i] = den[i];
    end
    v_input_valid = 1'b1;
    if (keep) begin
      exp_q0.push_back(exp);
      exp_t0.push_back(cyc + 3);
      exp_q1.push_back(exp);
      exp_t1.push_back(cyc + 2);
    end
  endtask

  // Idle cycles with scrambled data/mask: must never produce output beats.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v_input_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        v_input[i]        = $urandom;
        v_input_enable[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic set_lanes(input int base, input int mode);
    // mode 0: all on, 1: odd lanes on, 2: even lanes on
    for (int i = 0; i < 8; i++) begin
      din[i] = base + i;
      den[i] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(i % 2) : 1'((i + 1) % 2);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_valid: got valid with data %h at cycle %0d, required no output", out0, cyc);
      end else begin
        chk("dut0_sum", out0, exp_q0.pop_front());
        chk("dut0_latency", cyc, exp_t0.pop_front());
      end
    end
    if (rst_n === 1'b1 && vld1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_valid: got valid with data %h at cycle %0d, required no output", out1, cyc);
      end else begin
        chk("dut1_sum", out1, exp_q1.pop_front());
        chk("dut1_latency", cyc, exp_t1.pop_front());
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    v_input_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v_input[i]        = 32'sd0;
      v_input_enable[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("reset_out0", out0, 32'h0);
    chk("reset_vld0", 32'(vld0), 32'h0);
    chk("reset_out1", out1, 32'h0);
    chk("reset_vld1", 32'(vld1), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Single pulse, lanes 0..7, all enabled.
    set_lanes(0, 0);
    send(32'd28, 1'b1, 1'b0);
    idle(5);

    // Odd lanes only, then the inverted mask, back to back.
    for (int k = 0; k < 3; k++) begin
      set_lanes(k, 1);
      send(32'(16 + 4 * k), 1'b1, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      set_lanes(k, 2);
      send(32'(12 + 4 * k), 1'b1, 1'b0);
    end
    idle(4);

    // Four consecutive beats.
    for (int k = 0; k < 4; k++) begin
      set_lanes(k, 0);
      send(32'(28 + 8 * k), 1'b1, 1'b0);
    end
    idle(3);

    // Wrap-around and mask boundaries.
    for (int i = 0; i < 8; i++) begin
      din[i] = (i < 2) ? 32'sh7FFFFFFF : 32'sd0;
      den[i] = 1'b1;
    end
    send(32'hFFFFFFFE, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) din[i] = -32'sd1;
    send(32'hFFFFFFF8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      din[i] = 32'sh5A5A0000 + i;
      den[i] = 1'b0;
    end
    send(32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      din[i] = (i == 7) ? 32'sh12345678 : 32'shDEAD0000;
      den[i] = (i == 7);
    end
    send(32'h12345678, 1'b1, 1'b0);
    idle(6);

    // Reset one cycle after a pulse: the pulse must vanish.
    set_lanes(100, 0);
    send(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n         = 1'b0;
    v_input_valid = 1'b0;
    #1;
    chk("midrst_out0", out0, 32'h0);
    chk("midrst_vld0", 32'(vld0), 32'h0);
    chk("midrst_out1", out1, 32'h0);
    chk("midrst_vld1", 32'(vld1), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    // Reset again, releasing together with a beat: the first edge after
    // release must capture it.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din[i] = 10 * i;
      den[i] = 1'b1;
    end
    send(32'd280, 1'b1, 1'b1);
    idle(2);

    // Bounded drain.
    for (int n = 0; n < 30; n++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(negedge clk);
    end
    idle(3);
    chk("drain_q0_empty", 32'(exp_q0.size()), 32'h0);
    chk("drain_q1_empty", 32'(exp_q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
